main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//   Main-memory side of the cache refill/write-back interface: accepts one block
//   request at a time from the cache controller, streams a 4-word block back on a
//   read, or absorbs a 4-word block on a write-back. Models DRAM access latency.
//   Sits below the cache; byte array `memory[0:1023]` is hierarchically visible.
// PARAMETERS
//   ADDR_W     10  byte-address width (memory = 2**ADDR_W bytes)
//   WORD_W     32  data beat width
//   BLK_WORDS  4   words per block (block = 16 bytes, base aligned)
//   LATENCY    4   cycles from request accept to first read/write beat (>=1)
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   req_valid    in   1       cache presents a block request
//   req_ready    out  1       responder idle, request accepted when valid&ready
//   req_write    in   1       0 = block read (refill), 1 = block write-back
//   req_addr     in   ADDR_W  byte address; low 4 bits ignored (block aligned)
//   wdata        in   WORD_W  write-back beat data
//   wdata_valid  in   1       wdata holds a valid beat
//   wdata_ready  out  1       responder consumes beat when valid&ready
//   rdata        out  WORD_W  refill beat data
//   rdata_valid  out  1       rdata valid this cycle (no backpressure)
//   rdata_last   out  1       marks final refill beat
//   done         out  1       one-cycle pulse: transaction complete
// BEHAVIOUR
//   - Reset: FSM=IDLE, all memory bytes = 0x00, req_ready=1, all other outputs 0.
//   - Word packing little-endian: word = {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
//   - FSM: IDLE -> WAIT on accept (latch base = req_addr & ~0xF, write flag,
//     cnt=LATENCY-1, beat=0); WAIT counts down, at 0 -> RD or WR; RD/WR -> DONE
//     after beat BLK_WORDS-1; DONE -> IDLE after one cycle.
//   - Accept edge = T0. req_ready=1 only in IDLE; req_valid otherwise ignored.
//   - Read: rdata_valid=1 on cycles T0+LATENCY .. T0+LATENCY+3, beat k = word at
//     base+4k; rdata_last with beat 3; rdata=0 whenever rdata_valid=0.
//   - Write: wdata_ready=1 throughout WR; each valid&ready edge writes wdata to
//     base+4*beat, beat++; wdata_valid low stalls (no timeout). Earliest first
//     beat at T0+LATENCY.
//   - done=1 for exactly the cycle after the last beat; req_ready=1 the cycle after.
//   - Base aligned => a burst never crosses the top of memory; no wrap logic.
//   - Read after write-back to same block returns the written data (no bypass
//     needed: transactions are strictly serialised).
//   - Reset mid-transaction: immediate abort, FSM=IDLE, memory cleared, no done.
//   - Beat counter 2 bits, latency counter ceil(log2(LATENCY))+1 bits, saturate-free.
// STRUCTURE
//   - Shared header cache_defs.vh: BLK_WORDS, block offset width (4), FSM state
//     encodings (IDLE,WAIT,RD,WR,DONE), byte/word width constants; shared with
//     cache controllers.
//   - One sub-module: mem_byte_array (byte storage, 32-bit little-endian
//     word read/write port, async clear); FSM + counters in this module.
// TESTING
//   1. Reset, read req addr 0x000 -> beats 0,0,0,0; rdata_valid at T0+4..T0+7,
//      rdata_last at T0+7, done at T0+8, req_ready at T0+9.
//   2. Write req addr 0x005 with 0x000000FF,0x11,0x22,0x33 -> memory[0]=0xFF,
//      memory[4]=0x11, memory[8]=0x22, memory[12]=0x33; read 0x000 returns same.
//   3. Write to 0x3F0 with wdata_valid low 2 cycles between beats -> stalls, all
//      4 words stored at 0x3F0..0x3FF, done once, no writes outside the block.
//   4. req_valid held high through a read -> exactly one transaction; second
//      accepted only when req_ready returns; second read of 0x200 returns zeros.
//   5. Assert rst during RD beat 1 -> rdata_valid/done drop at once, memory[0]
//      reads 0x00 afterward, req_ready=1 after release.
//   6. LATENCY=1 build: read 0x010 -> first beat at T0+1, done at T0+5.

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
// Shared constants, FSM states and helpers for the block memory responder.
// Imported by the byte array and the responder top.
package main_mem_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int OFF_W  = 4;
  localparam int BEAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  // Byte offset of a beat inside its block.
  function automatic logic [OFF_W-1:0] beat_off(
    input logic [BEAT_W-1:0] beat
  );
    return {beat, 2'b00};
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage with one little-endian word write port, one async word read
// port and an asynchronous clear. Ports: clk, rst, we, waddr, wdata, raddr, rdata.
module mem_byte_array
  import main_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = WORD_W / BYTE_W;

  logic [BYTE_W-1:0] memory [0:DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        memory[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < NB; b++)
        memory[waddr + ADDR_W'(b)] <= wdata[BYTE_W*b +: BYTE_W];
    end
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < NB; b++)
      rdata[BYTE_W*b +: BYTE_W] = memory[raddr + ADDR_W'(b)];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: one block request at a time, fixed access latency,
// 4-beat refill stream or 4-beat write-back absorb, one-cycle done pulse.
// Ports: clk, rst, req_* (request), wdata* (write beats), rdata* (read beats), done.
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int WORD_W    = 32,
  parameter int BLK_WORDS = 4,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              rdata_last,
  output logic              done
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BLK_WORDS - 1);
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'((1 << OFF_W) - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] beat;
  logic              wr_q;
  logic [ADDR_W-1:0] beat_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_we;

  assign beat_addr = base | ADDR_W'(beat_off(beat));
  assign mem_we    = (state == S_WR) && wdata_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (req_valid) nxt = S_WAIT;
      S_WAIT: if (cnt == '0) nxt = wr_q ? S_WR : S_RD;
      S_RD:   if (beat == LAST) nxt = S_DONE;
      S_WR:   if (wdata_valid && beat == LAST) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == S_IDLE);
    wdata_ready = (state == S_WR);
    rdata_valid = (state == S_RD);
    rdata_last  = (state == S_RD) && (beat == LAST);
    rdata       = (state == S_RD) ? mem_rdata : '0;
    done        = (state == S_DONE);
  end

  // Request latch, latency countdown and beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
      wr_q <= 1'b0;
      cnt  <= '0;
      beat <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            base <= req_addr & AMASK;
            wr_q <= req_write;
            cnt  <= CNT_W'(LATENCY - 1);
            beat <= '0;
          end
        end
        S_WAIT: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        S_RD:   beat <= beat + BEAT_W'(1);
        S_WR:   if (wdata_valid) beat <= beat + BEAT_W'(1);
        default: ;
      endcase
    end
  end

  mem_byte_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (beat_addr),
    .wdata (wdata),
    .raddr (beat_addr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: table vectors, random
// transactions against a byte-array model, reset abort and LATENCY=1 build.
module tb_main_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] wdata, rdata;
  logic        wdata_valid, wdata_ready;
  logic        rdata_valid, rdata_last, done;

  logic        l_req_valid, l_req_ready, l_req_write;
  logic [9:0]  l_req_addr;
  logic [31:0] l_wdata, l_rdata;
  logic        l_wdata_valid, l_wdata_ready;
  logic        l_rdata_valid, l_rdata_last, l_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  main_mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
    .done(done)
  );

  main_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(l_req_valid), .req_ready(l_req_ready),
    .req_write(l_req_write), .req_addr(l_req_addr),
    .wdata(l_wdata), .wdata_valid(l_wdata_valid), .wdata_ready(l_wdata_ready),
    .rdata(l_rdata), .rdata_valid(l_rdata_valid), .rdata_last(l_rdata_last),
    .done(l_done)
  );

  typedef struct {
    bit           wr;
    logic [9:0]   addr;
    logic [127:0] data;
    logic [127:0] exp;
    int           gap;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [9:0] addr);
    logic [127:0] r;
    int b;
    b = int'(addr) & ~15;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_mem[b + i];
    return r;
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 1024; i++)
      if (dut.u_mem.memory[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic wait_ready(output int terr);
    int t = 0;
    terr = 0;
    while (req_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) terr = 1;
  endtask

  task automatic do_read(input logic [9:0] addr, input bit hold,
                         output logic [127:0] got, output int terr);
    logic [127:0] g;
    int e;
    g = '0;
    wait_ready(e);
    terr = e;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int n = 0; n <= LAT + 5; n++) begin
      if (n > 0) @(negedge clk);
      if (rdata_valid !== (n >= LAT && n <= LAT + 3)) terr++;
      if (rdata_last !== (n == LAT + 3)) terr++;
      if (done !== (n == LAT + 4)) terr++;
      if (req_ready !== (n == LAT + 5)) terr++;
      if (rdata_valid !== 1'b1 && rdata !== 32'h0) terr++;
      if (n >= LAT && n <= LAT + 3) g[32*(n-LAT) +: 32] = rdata;
    end
    got = g;
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [127:0] data,
                          input int gap, output int terr);
    int k, stall, first, dones, n, e;
    bit fin;
    k = 0; stall = 0; first = -1; dones = 0; n = 0; fin = 0;
    wait_ready(e);
    terr = e;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    while (n < 300 && !fin) begin
      if (done === 1'b1) dones++;
      if (wdata_ready === 1'b1 && first < 0) first = n;
      if (req_ready === 1'b1) begin
        fin = 1;
      end else begin
        if (wdata_ready === 1'b1 && k < 4 && stall == 0) begin
          wdata_valid = 1'b1;
          wdata = data[32*k +: 32];
          k++;
          stall = gap;
        end else begin
          wdata_valid = 1'b0;
          wdata = $urandom;
          if (wdata_ready === 1'b1 && stall > 0) stall--;
        end
        @(negedge clk);
        n++;
      end
    end
    wdata_valid = 1'b0;
    if (!fin) terr++;
    if (first != LAT) terr++;
    if (dones != 1) terr++;
    if (k != 4) terr++;
    for (int i = 0; i < 16; i++)
      ref_mem[(int'(addr) & ~15) + i] = data[8*i +: 8];
  endtask

  vec_t vecs[6];

  initial begin
    logic [127:0] got, d;
    int terr, wr, gap;
    logic [9:0] a;

    vecs[0] = '{0, 10'h000, 128'h0, 128'h0, 0};
    vecs[1] = '{1, 10'h005,
                128'h00000033_00000022_00000011_000000FF, 128'h0, 0};
    vecs[2] = '{0, 10'h000, 128'h0,
                128'h00000033_00000022_00000011_000000FF, 0};
    vecs[3] = '{1, 10'h3F0,
                128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 128'h0, 2};
    vecs[4] = '{0, 10'h3F4, 128'h0,
                128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0};
    vecs[5] = '{0, 10'h200, 128'h0, 128'h0, 0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0;
    wdata = '0; wdata_valid = 0;
    l_req_valid = 0; l_req_write = 0; l_req_addr = '0;
    l_wdata = '0; l_wdata_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_outputs",
          {req_ready, wdata_ready, rdata_valid, rdata_last, done, rdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    check("reset_mem", mem_diff(), 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].gap, terr);
        check($sformatf("vec%0d_wr_timing", i), terr, 0);
        check($sformatf("vec%0d_mem", i), mem_diff(), 0);
      end else begin
        do_read(vecs[i].addr, 0, got, terr);
        check($sformatf("vec%0d_rd_timing", i), terr, 0);
        check($sformatf("vec%0d_rd_data", i), got, vecs[i].exp);
      end
    end
    check("mem0_ff", dut.u_mem.memory[0], 8'hFF);
    check("mem12_33", dut.u_mem.memory[12], 8'h33);

    for (int t = 0; t < 24; t++) begin
      wr  = $urandom_range(0, 1);
      a   = 10'($urandom_range(0, 1023));
      gap = $urandom_range(0, 2);
      d   = {$urandom, $urandom, $urandom, $urandom};
      if (wr != 0) begin
        do_write(a, d, gap, terr);
        check($sformatf("rnd%0d_wr_timing", t), terr, 0);
        check($sformatf("rnd%0d_mem", t), mem_diff(), 0);
      end else begin
        do_read(a, 0, got, terr);
        check($sformatf("rnd%0d_rd_timing", t), terr, 0);
        check($sformatf("rnd%0d_rd_data", t), got, ref_block(a));
      end
    end

    do_read(10'h200, 1, got, terr);
    check("hold_first_timing", terr, 0);
    check("hold_first_data", got, ref_block(10'h200));
    do_read(10'h200, 0, got, terr);
    check("hold_second_timing", terr, 0);
    check("hold_second_data", got, ref_block(10'h200));

    do_write(10'h000, 128'h44444444_33333333_22222222_11111111, 0, terr);
    check("pre_abort_write", terr, 0);
    wait_ready(terr);
    check("abort_ready", terr, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("abort_beat1", {rdata_valid, rdata}, {1'b1, 32'h22222222});
    #1 rst = 1'b1;
    #1;
    check("abort_drop", {rdata_valid, rdata_last, done, rdata}, 35'h0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    check("abort_mem0", dut.u_mem.memory[0], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release", {req_ready, done}, {1'b1, 1'b0});
    check("abort_mem_all", mem_diff(), 0);
    do_read(10'h000, 0, got, terr);
    check("post_abort_timing", terr, 0);
    check("post_abort_data", got, 128'h0);

    terr = 0;
    l_req_valid = 1'b1; l_req_write = 1'b0; l_req_addr = 10'h010;
    @(negedge clk);
    l_req_valid = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk);
      if (l_rdata_valid !== (n >= 1 && n <= 4)) terr++;
      if (l_rdata_last !== (n == 4)) terr++;
      if (l_done !== (n == 5)) terr++;
      if (l_req_ready !== (n == 6)) terr++;
      if (l_rdata !== 32'h0) terr++;
    end
    check("lat1_read", terr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
